uart_reg_responder: RTL and testbench

- Sits between `UART_RX` and `UART_TX` and acts as the responder end of the team's host-to-FPGA UART link.
- Parses host command frames from the receiver's byte stream, performs one register read or write on a simple local register bus, and returns one response byte through the transmitter.
- Malformed, stale or overlapping traffic is dropped or answered with an error byte; every such event is counted.

---
 rtl/uart_reg_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_reg_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Responder end of the host UART link: parses 'W'/'R' command frames from UART_RX,
// performs one local register access and returns one response byte through UART_TX.
module uart_reg_responder #(
  parameter int ADDR_WIDTH   = 4,
  parameter int TIMEOUT_CLKS = 21700
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  input  logic                  i_TX_Active,
  input  logic                  i_TX_Done,
  output logic [ADDR_WIDTH-1:0] o_Reg_Addr,
  output logic                  o_Reg_Wr_En,
  output logic [7:0]            o_Reg_Wr_Data,
  output logic                  o_Reg_Rd_En,
  input  logic [7:0]            i_Reg_Rd_Data,
  output logic                  o_Busy,
  output logic [7:0]            o_Err_Count
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       OP_WRITE = 8'h57;
  localparam logic [7:0]       OP_READ  = 8'h52;
  localparam logic [7:0]       RSP_OK   = 8'h4B;
  localparam logic [7:0]       RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GET_DATA     = 3'd2,
    REG_ACCESS   = 3'd3,
    READ_CAPTURE = 3'd4,
    SEND         = 3'd5,
    WAIT_ACT     = 3'd6,
    WAIT_DONE    = 3'd7
  } state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic addr_ok(input logic [7:0] b);
    return (b >> ADDR_WIDTH) == 8'h00;
  endfunction

  state_t                state_r, state_s;
  logic                  is_write_r, is_write_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [7:0]            tx_byte_r, tx_byte_s;
  logic [ADDR_WIDTH-1:0] reg_addr_r;
  logic [7:0]            wr_data_r;
  logic                  wr_en_r, rd_en_r, busy_r;
  logic [7:0]            err_count_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  tx_idle_s, timeout_s, overlap_s, fsm_err_s, tx_dv_s;
  logic [1:0]            err_inc_s;

  assign tx_idle_s = !i_TX_Active && !i_TX_Done;
  assign timeout_s = (cnt_r == CNT_LAST) && !i_RX_DV;
  assign overlap_s = i_RX_DV && (state_r != IDLE) && (state_r != GET_ADDR) && (state_r != GET_DATA);
  assign err_inc_s = {1'b0, fsm_err_s} + {1'b0, overlap_s};

  // Next-state, frame context and response selection
  always_comb begin
    state_s    = state_r;
    is_write_s = is_write_r;
    addr_s     = addr_r;
    tx_byte_s  = tx_byte_r;
    fsm_err_s  = 1'b0;
    tx_dv_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_RX_DV) begin
          if ((i_RX_Byte == OP_WRITE) || (i_RX_Byte == OP_READ)) begin
            state_s    = GET_ADDR;
            is_write_s = (i_RX_Byte == OP_WRITE);
          end else begin
            state_s   = SEND;
            tx_byte_s = RSP_ERR;
            fsm_err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GET_ADDR: begin
        if (i_RX_DV) begin
          if (!addr_ok(i_RX_Byte)) begin
            state_s   = SEND;
            tx_byte_s = RSP_ERR;
            fsm_err_s = 1'b1;
          end else begin
            addr_s  = i_RX_Byte[ADDR_WIDTH-1:0];
            state_s = is_write_r ? GET_DATA : REG_ACCESS;
          end
        end else if (timeout_s) begin
          state_s   = IDLE;
          fsm_err_s = 1'b1;
        end else begin
          state_s = GET_ADDR;
        end
      end
      GET_DATA: begin
        if (i_RX_DV) begin
          state_s = REG_ACCESS;
        end else if (timeout_s) begin
          state_s   = IDLE;
          fsm_err_s = 1'b1;
        end else begin
          state_s = GET_DATA;
        end
      end
      REG_ACCESS: begin
        if (is_write_r) begin
          state_s   = SEND;
          tx_byte_s = RSP_OK;
        end else begin
          state_s = READ_CAPTURE;
        end
      end
      READ_CAPTURE: begin
        tx_byte_s = i_Reg_Rd_Data;
        state_s   = SEND;
      end
      SEND: begin
        // Request fires in the first SEND cycle the transmitter is idle.
        if (tx_idle_s) begin
          tx_dv_s = 1'b1;
          state_s = WAIT_ACT;
        end else begin
          state_s = SEND;
        end
      end
      WAIT_ACT: begin
        if (i_TX_Active) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_ACT;
        end
      end
      WAIT_DONE: begin
        if (tx_idle_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and per-frame context
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r    <= IDLE;
      is_write_r <= 1'b0;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      tx_byte_r  <= 8'h00;
    end else begin
      state_r    <= state_s;
      is_write_r <= is_write_s;
      addr_r     <= addr_s;
      tx_byte_r  <= tx_byte_s;
    end
  end

  // Register bus: address/data only change when a strobe is issued
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      reg_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= 8'h00;
      wr_en_r    <= 1'b0;
      rd_en_r    <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      rd_en_r <= 1'b0;
      if (state_s == REG_ACCESS) begin
        reg_addr_r <= addr_s;
        wr_en_r    <= is_write_r;
        rd_en_r    <= !is_write_r;
        if (is_write_r) begin
          wr_data_r <= i_RX_Byte;
        end
      end
    end
  end

  // Inter-byte timeout counter, cleared by every received byte
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_RX_DV) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == GET_ADDR) || (state_r == GET_DATA)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Saturating error counter and busy flag
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      err_count_r <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      err_count_r <= sat_add(err_count_r, err_inc_s);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign o_TX_DV       = tx_dv_s;
  assign o_TX_Byte     = tx_byte_r;
  assign o_Reg_Addr    = reg_addr_r;
  assign o_Reg_Wr_En   = wr_en_r;
  assign o_Reg_Wr_Data = wr_data_r;
  assign o_Reg_Rd_En   = rd_en_r;
  assign o_Busy        = busy_r;
  assign o_Err_Count   = err_count_r;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench for uart_reg_responder: behavioural UART_TX and register-bus
// models around the DUT, frame-level reference model for responses and error counts.
module tb_uart_reg_responder;

  localparam int AW     = 4;
  localparam int TO     = 64;
  localparam int TX_LEN = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;
  logic [AW-1:0] reg_addr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [7:0]    rd_data = 8'h00;
  logic          busy;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  uart_reg_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_TX_Active(tx_active), .i_TX_Done(tx_done),
    .o_Reg_Addr(reg_addr), .o_Reg_Wr_En(wr_en), .o_Reg_Wr_Data(wr_data),
    .o_Reg_Rd_En(rd_en), .i_Reg_Rd_Data(rd_data), .o_Busy(busy), .o_Err_Count(err_count)
  );

  // Register bus model: read data appears the cycle after the read strobe.
  logic [7:0] bus_mem [16] = '{default: 8'h00};
  int wr_seen = 0;
  int rd_seen = 0;
  always @(posedge clk) begin
    if (wr_en) begin
      bus_mem[reg_addr] <= wr_data;
      wr_seen <= wr_seen + 1;
    end
    if (rd_en) begin
      rd_data <= bus_mem[reg_addr];
      rd_seen <= rd_seen + 1;
    end
  end

  // UART_TX model: busy TX_LEN cycles, then two cycles of done (cleanup), then idle.
  int         tx_phase = 0;
  int         tx_cnt = 0;
  int         tx_n = 0;
  int         dv_seen = 0;
  int         dv_bad = 0;
  logic [7:0] tx_log [1024];
  always @(posedge clk) begin
    if (tx_dv) begin
      dv_seen <= dv_seen + 1;
      if (tx_phase != 0 || tx_active || tx_done) dv_bad <= dv_bad + 1;
    end
    case (tx_phase)
      0: if (tx_dv) begin
        tx_log[tx_n % 1024] <= tx_byte;
        tx_n      <= tx_n + 1;
        tx_active <= 1'b1;
        tx_cnt    <= TX_LEN;
        tx_phase  <= 1;
      end
      1: if (tx_cnt == 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        tx_cnt    <= 2;
        tx_phase  <= 2;
      end else tx_cnt <= tx_cnt - 1;
      2: if (tx_cnt == 1) begin
        tx_done  <= 1'b0;
        tx_phase <= 0;
      end else tx_cnt <= tx_cnt - 1;
      default: tx_phase <= 0;
    endcase
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ref_err = 0;
  logic [7:0] ref_regs [16] = '{default: 8'h00};

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  // Bytes arrive 'gap' cycles apart; returns at the negedge after the last byte (N+1).
  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int gap);
    logic [7:0] bs [3];
    bs = '{b0, b1, b2};
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap - 1) @(negedge clk);
      send_byte(bs[i]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy !== 1'b0 || tx_phase != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0 || tx_phase != 0) begin
      n_bad++;
      $display("FAIL %s_idle: busy=%b tx_phase=%0d, required idle within 400 cycles", tag, busy, tx_phase);
    end
  endtask

  task automatic bump_err();
    if (ref_err < 255) ref_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_dv, tx_byte, reg_addr, wr_en, wr_data, rd_en, busy, err_count} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required 0", {tx_dv, tx_byte, reg_addr, wr_en, wr_data, rd_en, busy, err_count});
    end
    rst = 1'b0;
    ref_err = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || err_count !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b err=%0d, required 0/0", busy, err_count);
    end
  endtask

  task automatic test_write();
    int w0, t0;
    w0 = wr_seen; t0 = tx_n;
    send_frame(3, 8'h57, 8'h03, 8'hA5, 2);
    n_cmp++;
    if (wr_en !== 1'b1 || reg_addr !== 4'h3 || wr_data !== 8'hA5 || tx_dv !== 1'b0) begin
      n_bad++;
      $display("FAIL write_n1: wr_en=%b addr=%h data=%h tx_dv=%b, required 1/3/a5/0", wr_en, reg_addr, wr_data, tx_dv);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_en !== 1'b0 || tx_dv !== 1'b1 || tx_byte !== 8'h4B) begin
      n_bad++;
      $display("FAIL write_n2: wr_en=%b tx_dv=%b tx_byte=%h, required 0/1/4b", wr_en, tx_dv, tx_byte);
    end
    wait_idle("write");
    ref_regs[3] = 8'hA5;
    n_cmp++;
    if (tx_n - t0 != 1 || tx_log[(tx_n - 1) % 1024] !== 8'h4B || wr_seen - w0 != 1) begin
      n_bad++;
      $display("FAIL write_result: bytes=%0d last=%h writes=%0d, required 1/4b/1", tx_n - t0, tx_log[(tx_n - 1) % 1024], wr_seen - w0);
    end
  endtask

  task automatic test_read();
    int d0, r0;
    send_frame(3, 8'h57, 8'h0C, 8'h3C, 1);
    wait_idle("read_setup");
    ref_regs[12] = 8'h3C;
    d0 = dv_seen; r0 = rd_seen;
    send_frame(2, 8'h52, 8'h0C, 8'h00, 3);
    n_cmp++;
    if (rd_en !== 1'b1 || reg_addr !== 4'hC || wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL read_n1: rd_en=%b addr=%h wr_en=%b, required 1/c/0", rd_en, reg_addr, wr_en);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b0 || tx_dv !== 1'b0) begin
      n_bad++;
      $display("FAIL read_n2: rd_en=%b tx_dv=%b, required 0/0", rd_en, tx_dv);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h3C) begin
      n_bad++;
      $display("FAIL read_n3: tx_dv=%b tx_byte=%h, required 1/3c", tx_dv, tx_byte);
    end
    wait_idle("read");
    n_cmp++;
    if (dv_seen - d0 != 1 || rd_seen - r0 != 1 || tx_log[(tx_n - 1) % 1024] !== 8'h3C) begin
      n_bad++;
      $display("FAIL read_result: dv=%0d reads=%0d last=%h, required 1/1/3c", dv_seen - d0, rd_seen - r0, tx_log[(tx_n - 1) % 1024]);
    end
  endtask

  task automatic test_errors();
    int s0, t0;
    s0 = wr_seen + rd_seen; t0 = tx_n;
    send_frame(1, 8'h11, 8'h00, 8'h00, 1);
    bump_err();
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h45 || err_count !== ref_err[7:0]) begin
      n_bad++;
      $display("FAIL badop_n1: tx_dv=%b tx_byte=%h err=%0d, required 1/45/%0d", tx_dv, tx_byte, err_count, ref_err);
    end
    wait_idle("badop");
    send_frame(2, 8'h52, 8'h20, 8'h00, 2);
    bump_err();
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h45 || rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL badaddr_n1: tx_dv=%b tx_byte=%h rd_en=%b, required 1/45/0", tx_dv, tx_byte, rd_en);
    end
    wait_idle("badaddr");
    n_cmp++;
    if (err_count !== 8'd2 || wr_seen + rd_seen != s0 || tx_n - t0 != 2 || tx_log[(tx_n - 1) % 1024] !== 8'h45) begin
      n_bad++;
      $display("FAIL errors_result: err=%0d strobes=%0d bytes=%0d last=%h, required 2/0/2/45", err_count, wr_seen + rd_seen - s0, tx_n - t0, tx_log[(tx_n - 1) % 1024]);
    end
  endtask

  task automatic test_gap_boundary();
    int t0;
    t0 = tx_n;
    send_frame(3, 8'h57, 8'h05, 8'h5A, TO);
    wait_idle("gap_max");
    ref_regs[5] = 8'h5A;
    n_cmp++;
    if (tx_n - t0 != 1 || tx_log[(tx_n - 1) % 1024] !== 8'h4B || err_count !== ref_err[7:0]) begin
      n_bad++;
      $display("FAIL gap_max: bytes=%0d last=%h err=%0d, required 1/4b/%0d", tx_n - t0, tx_log[(tx_n - 1) % 1024], err_count, ref_err);
    end
  endtask

  task automatic test_timeout();
    int s0, t0;
    s0 = wr_seen + rd_seen; t0 = tx_n;
    send_frame(2, 8'h57, 8'h01, 8'h00, 2);
    repeat (TO - 3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_early: busy=%b, required 1", busy);
    end
    repeat (3) @(negedge clk);
    bump_err();
    n_cmp++;
    if (busy !== 1'b0 || err_count !== ref_err[7:0] || tx_n != t0 || wr_seen + rd_seen != s0) begin
      n_bad++;
      $display("FAIL timeout_abort: busy=%b err=%0d bytes=%0d strobes=%0d, required 0/%0d/0/0", busy, err_count, tx_n - t0, wr_seen + rd_seen - s0, ref_err);
    end
    send_frame(3, 8'h57, 8'h07, 8'hC3, 3);
    wait_idle("timeout_after");
    ref_regs[7] = 8'hC3;
    n_cmp++;
    if (tx_n - t0 != 1 || tx_log[(tx_n - 1) % 1024] !== 8'h4B || wr_seen - s0 + rd_seen != 1) begin
      n_bad++;
      $display("FAIL timeout_recover: bytes=%0d last=%h strobes=%0d, required 1/4b/1", tx_n - t0, tx_log[(tx_n - 1) % 1024], wr_seen + rd_seen - s0);
    end
  endtask

  task automatic test_overlap();
    int d0, k;
    d0 = dv_seen;
    send_frame(3, 8'h57, 8'h09, 8'h99, 3);
    ref_regs[9] = 8'h99;
    k = 0;
    while (tx_active !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    send_byte(8'hFF);
    bump_err();
    wait_idle("overlap");
    n_cmp++;
    if (err_count !== ref_err[7:0] || dv_seen - d0 != 1 || tx_log[(tx_n - 1) % 1024] !== 8'h4B) begin
      n_bad++;
      $display("FAIL overlap: err=%0d dv=%0d last=%h, required %0d/1/4b", err_count, dv_seen - d0, tx_log[(tx_n - 1) % 1024], ref_err);
    end
  endtask

  task automatic test_random();
    int w0, r0, exp_w, exp_r, t0, kind, gap;
    logic [7:0] op, a, d, exp_rsp;
    w0 = wr_seen; r0 = rd_seen; exp_w = 0; exp_r = 0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      gap  = $urandom_range(1, 6);
      a    = 8'($urandom_range(0, 15));
      d    = 8'($urandom);
      t0   = tx_n;
      if (kind == 0) begin
        send_frame(3, 8'h57, a, d, gap);
        ref_regs[a[3:0]] = d; exp_w++; exp_rsp = 8'h4B;
      end else if (kind == 1) begin
        send_frame(2, 8'h52, a, 8'h00, gap);
        exp_r++; exp_rsp = ref_regs[a[3:0]];
      end else if (kind == 2) begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        send_frame(1, op, 8'h00, 8'h00, gap);
        bump_err(); exp_rsp = 8'h45;
      end else begin
        a = 8'($urandom_range(16, 255));
        send_frame(2, ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52, a, 8'h00, gap);
        bump_err(); exp_rsp = 8'h45;
      end
      wait_idle("random");
      n_cmp++;
      if (tx_n - t0 != 1 || tx_log[(tx_n - 1) % 1024] !== exp_rsp || err_count !== ref_err[7:0]) begin
        n_bad++;
        $display("FAIL random_%0d: kind=%0d bytes=%0d rsp=%h err=%0d, required 1/%h/%0d", it, kind, tx_n - t0, tx_log[(tx_n - 1) % 1024], err_count, exp_rsp, ref_err);
      end
    end
    n_cmp++;
    if (wr_seen - w0 != exp_w || rd_seen - r0 != exp_r) begin
      n_bad++;
      $display("FAIL random_strobes: writes=%0d reads=%0d, required %0d/%0d", wr_seen - w0, rd_seen - r0, exp_w, exp_r);
    end
  endtask

  task automatic test_reset_mid();
    int k, t0, b0;
    send_frame(3, 8'h57, 8'h0D, 8'h6E, 2);
    wait_idle("rstmid_setup");
    ref_regs[13] = 8'h6E;
    send_frame(2, 8'h52, 8'h0D, 8'h00, 2);
    k = 0;
    while (tx_active !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_err = 0;
    n_cmp++;
    if ({tx_dv, tx_byte, reg_addr, wr_en, wr_data, rd_en, busy, err_count} !== 32'h0 || tx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h tx_active=%b, required 0 with tx_active=1", {tx_dv, tx_byte, reg_addr, wr_en, wr_data, rd_en, busy, err_count}, tx_active);
    end
    t0 = tx_n; b0 = dv_bad;
    send_frame(2, 8'h52, 8'h0D, 8'h00, 1);
    wait_idle("rstmid");
    n_cmp++;
    if (dv_bad != b0 || tx_n - t0 != 1 || tx_log[(tx_n - 1) % 1024] !== 8'h6E || err_count !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_next: early_dv=%0d bytes=%0d last=%h err=%0d, required 0/1/6e/0", dv_bad - b0, tx_n - t0, tx_log[(tx_n - 1) % 1024], err_count);
    end
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 300; n++) begin
      send_frame(1, 8'h11, 8'h00, 8'h00, 1);
      bump_err();
      wait_idle("sat");
      if (n == 254 || n == 255 || n == 300) begin
        n_cmp++;
        if (err_count !== ref_err[7:0]) begin
          n_bad++;
          $display("FAIL sat_%0d: err=%0d, required %0d", n, err_count, ref_err);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_gap_boundary();
    test_timeout();
    test_overlap();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
